// File: rtl/addsub_sequencer.sv
// Control FSM for the add/subtract accumulator datapath: loads A, then applies up to
// three held add/sub steps (B, C, D) and pulses result_valid when the result is ready.
module addsub_sequencer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] terms,
    input  logic [2:0] op,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       addOrSub,
    output logic       done,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] step
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STEP   = 2'd2,
        FINISH = 2'd3
    } stateT;

    localparam logic [3:0] LAST_COUNT = 4'(STEP_CYCLES - 1);

    stateT      state;
    stateT      stateNext;
    logic [1:0] stepIdx;
    logic [1:0] stepIdxNext;
    logic [3:0] cycleCount;
    logic [3:0] cycleCountNext;
    logic [2:0] opReg;
    logic [2:0] opRegNext;
    logic [1:0] termsReg;
    logic [1:0] termsRegNext;
    logic       stepOp;

    // State register; the step index, hold counter and latched request live alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            stepIdx    <= 2'd0;
            cycleCount <= 4'd0;
            opReg      <= 3'd0;
            termsReg   <= 2'd0;
        end else begin
            state      <= stateNext;
            stepIdx    <= stepIdxNext;
            cycleCount <= cycleCountNext;
            opReg      <= opRegNext;
            termsReg   <= termsRegNext;
        end
    end

    // Next-state logic. The step index is left untouched on the way into FINISH so the
    // operand select and add/sub direction stay stable through the final cycle.
    always_comb begin
        stateNext      = state;
        stepIdxNext    = stepIdx;
        cycleCountNext = cycleCount;
        opRegNext      = opReg;
        termsRegNext   = termsReg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    opRegNext      = op;
                    termsRegNext   = terms;
                    stepIdxNext    = 2'd0;
                    cycleCountNext = 4'd0;
                    stateNext      = LOAD;
                end
            end
            LOAD: begin
                stepIdxNext    = 2'd0;
                cycleCountNext = 4'd0;
                stateNext      = (termsReg == 2'd0) ? FINISH : STEP;
            end
            STEP: begin
                if (cycleCount == LAST_COUNT) begin
                    cycleCountNext = 4'd0;
                    if (stepIdx == termsReg - 2'd1) begin
                        stateNext = FINISH;
                    end else begin
                        stepIdxNext = stepIdx + 2'd1;
                    end
                end else begin
                    cycleCountNext = cycleCount + 4'd1;
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        stepOp = 1'b1;
        case (stepIdx)
            2'd0:    stepOp = opReg[0];
            2'd1:    stepOp = opReg[1];
            2'd2:    stepOp = opReg[2];
            default: stepOp = 1'b1;
        endcase
    end

    // Output decode from registered state only; done stays high outside STEP so the
    // datapath never does arithmetic except while a step is being held.
    always_comb begin
        s0           = 1'b0;
        s1           = 1'b0;
        s2           = 1'b0;
        addOrSub     = 1'b1;
        done         = 1'b1;
        busy         = 1'b0;
        result_valid = 1'b0;
        step         = 2'd0;
        unique case (state)
            IDLE: begin
            end
            LOAD: begin
                busy = 1'b1;
            end
            STEP: begin
                s0       = 1'b1;
                s1       = stepIdx[0];
                s2       = stepIdx[1];
                addOrSub = stepOp;
                done     = 1'b0;
                busy     = 1'b1;
                step     = stepIdx;
            end
            FINISH: begin
                s0           = (termsReg != 2'd0);
                s1           = stepIdx[0];
                s2           = stepIdx[1];
                addOrSub     = (termsReg == 2'd0) ? 1'b1 : stepOp;
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Multicycle control FSM that drives the control inputs of the add/subtract accumulator datapath.
- Datapath side consumes `s0`, `s1`, `s2`, `addOrSub` and `done`.
- On a start request it loads operand A, then applies up to three add/subtract steps using B, C and D in that order.
- Each step is held for a programmable number of cycles so the datapath can settle.
- Signals completion to the upstream requester with `busy` and `result_valid`.

Parameters:
- STEP_CYCLES, 2, cycles each add/sub step is held. Legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new computation; sampled only in IDLE.
- terms  input  2  number of steps to apply after loading A: 0..3 (B, then C, then D).
- op  input  3  per-step operation: op[0] for B, op[1] for C, op[2] for D. 1 = add, 0 = subtract.
- s0  output  1  accumulator source select: 0 = load A, 1 = feed back the add/sub result.
- s1  output  1  operand select, low bit.
- s2  output  1  operand select, high bit. {s2,s1}: 00 = B, 01 = C, 10 = D; 11 is never driven.
- addOrSub  output  1  1 = add, 0 = subtract.
- done  output  1  datapath hold: 1 freezes the datapath arithmetic, 0 enables it.
- busy  output  1  high whenever the FSM is not in IDLE.
- result_valid  output  1  one-cycle pulse when the accumulator holds the final result.
- step  output  2  index of the current step (0 = B, 1 = C, 2 = D); 0 outside STEP.

Behaviour:
- Reset
  - Synchronous; overrides everything, including mid-operation: next state is IDLE.
  - Output values in reset/IDLE: s0=0, s1=0, s2=0, addOrSub=1, done=1, busy=0, result_valid=0, step=0.
  - Internal counter, op_reg and terms_reg clear to 0.
- States: IDLE, LOAD, STEP, FINISH.
- IDLE
  - Holds the reset outputs.
  - start=1 at an edge: latch op_reg<=op and terms_reg<=terms, then go to LOAD.
- LOAD (exactly 1 cycle)
  - Outputs: s0=0, {s2,s1}=00, done=1, busy=1.
  - If terms_reg=0, go to FINISH; otherwise go to STEP with step=0 and the counter cleared.
- STEP
  - Outputs: s0=1, {s2,s1}=step encoding, addOrSub=op_reg[step], done=0, busy=1.
  - Counter increments every cycle. When the counter reaches STEP_CYCLES-1:
    - if step=terms_reg-1, go to FINISH;
    - otherwise increment step and clear the counter.
  - Select and addOrSub change only on step boundaries, never mid-step.
- FINISH (exactly 1 cycle)
  - Outputs: done=1, result_valid=1, busy=1.
  - s0 = (terms_reg≠0); {s2,s1} and addOrSub hold their last STEP values (00 and 1 if terms_reg=0).
  - Next state is IDLE.
- Latency: result_valid is high in the cycle beginning at edge 1+terms×STEP_CYCLES after the edge that sampled start.
- start while busy is ignored (not queued). start held high continuously begins a new request on the first IDLE cycle after FINISH.
- op and terms may change freely after the start edge; only latched values are used.
- done must be 1 in every non-STEP cycle, so no arithmetic is triggered outside STEP.
- All outputs are registered or decoded purely from registered state; no combinational path from start/op/terms to any output.

Test Plan:
- Reset, then hold idle 5 cycles → s0=0, {s2,s1}=00, addOrSub=1, done=1, busy=0, result_valid=0 throughout.
- STEP_CYCLES=2, start with terms=3, op=3'b101 →
  - LOAD for 1 cycle.
  - B add for 2 cycles, C subtract for 2 cycles, D add for 2 cycles, done=0 in all six.
  - result_valid for one cycle at edge 7; busy falls at edge 8.
  - With the datapath attached and A=10, B=5, C=3, D=1, the accumulator reads 13.
- terms=0, start → LOAD then FINISH with s0=0 and result_valid at edge 1; done never 0; datapath holds A.
- terms=2, op=3'b000, start pulsed again during STEP → second start ignored; exactly one result_valid pulse; {s2,s1}=11 never observed.
- Reset asserted during the second step of a 3-term run → IDLE outputs from the following edge; no result_valid; a fresh start afterwards completes normally.
- STEP_CYCLES=1, terms=3, start held high continuously → back-to-back runs, result_valid at edge 4 of each run, exactly one IDLE cycle between runs.
